// File: rtl/reg_bank_param.sv
// General-purpose register file: DEPTH x DATA_WIDTH storage, one write port and
// two registered read ports, with optional hardwired-zero register 0 and write-to-read bypass.
module reg_bank_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] RADDR1,
  input  logic [ADDR_WIDTH-1:0] RADDR2,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [DATA_WIDTH-1:0] RDATA2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0]      load_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_next;
  logic [DATA_WIDTH-1:0] rd2_next;

  // Selects what a read port captures: stored value, forwarded write data, or
  // the hardwired zero. load_en already excludes discarded zero-register writes.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  hit,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] val;
    val = stored;
    if ((BYPASS != 0) && hit) val = wdata;
    if ((ZERO_REG != 0) && (raddr == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    load_en = '0;
    if (WE) load_en[WADDR] = 1'b1;
    if (ZERO_REG != 0) load_en[0] = 1'b0;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        q <= '0;
      end else if (load_en[i]) begin
        q <= WDATA;
      end
    end

    assign mem[i] = q;
  end

  always_comb begin
    rd1_next = read_sel(RADDR1, mem[RADDR1], load_en[RADDR1], WDATA);
    rd2_next = read_sel(RADDR2, mem[RADDR2], load_en[RADDR2], WDATA);
  end

  // Read stage boundary: one-cycle registered outputs, held while RE is low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RDATA1 <= '0;
      RDATA2 <= '0;
    end else if (RE) begin
      RDATA1 <= rd1_next;
      RDATA2 <= rd2_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: four builds covering zero-register, bypass
// and narrow-width parametrisations, with expected values written out by hand.
module tb_reg_bank_param;

  logic        CLK;
  logic        RESET;

  logic        a_we, a_re;
  logic [4:0]  a_waddr, a_raddr1, a_raddr2;
  logic [31:0] a_wdata;
  logic [31:0] z1_rd1, z1_rd2, z0_rd1, z0_rd2;

  logic        c_we, c_re;
  logic [2:0]  c_waddr, c_raddr1, c_raddr2;
  logic [7:0]  c_wdata;
  logic [7:0]  n1_rd1, n1_rd2, n0_rd1, n0_rd2;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_z1b1 (
    .CLK(CLK), .RESET(RESET), .WE(a_we), .WADDR(a_waddr), .WDATA(a_wdata),
    .RE(a_re), .RADDR1(a_raddr1), .RADDR2(a_raddr2), .RDATA1(z1_rd1), .RDATA2(z1_rd2));

  reg_bank_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_z0b0 (
    .CLK(CLK), .RESET(RESET), .WE(a_we), .WADDR(a_waddr), .WDATA(a_wdata),
    .RE(a_re), .RADDR1(a_raddr1), .RADDR2(a_raddr2), .RDATA1(z0_rd1), .RDATA2(z0_rd2));

  reg_bank_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) u_n1 (
    .CLK(CLK), .RESET(RESET), .WE(c_we), .WADDR(c_waddr), .WDATA(c_wdata),
    .RE(c_re), .RADDR1(c_raddr1), .RADDR2(c_raddr2), .RDATA1(n1_rd1), .RDATA2(n1_rd2));

  reg_bank_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u_n0 (
    .CLK(CLK), .RESET(RESET), .WE(c_we), .WADDR(c_waddr), .WDATA(c_wdata),
    .RE(c_re), .RADDR1(c_raddr1), .RADDR2(c_raddr2), .RDATA1(n0_rd1), .RDATA2(n0_rd2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] e1, e2;
    int         j;

    RESET = 1'b1;
    a_we = 1'b0; a_re = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr1 = '0; a_raddr2 = '0;
    c_we = 1'b0; c_re = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr1 = '0; c_raddr2 = '0;

    // Asynchronous reset before any clock edge
    #1 RESET = 1'b0;
    #2;
    check("rst_z1_rd1", z1_rd1, 32'h0);
    check("rst_z0_rd2", z0_rd2, 32'h0);
    check("rst_n1_rd1", {24'h0, n1_rd1}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // First reads after reset
    a_re = 1'b1; a_raddr1 = 5'd3; a_raddr2 = 5'd31;
    tick();
    check("post_rst_z1_rd1", z1_rd1, 32'h0);
    check("post_rst_z1_rd2", z1_rd2, 32'h0);
    check("post_rst_z0_rd1", z0_rd1, 32'h0);
    check("post_rst_z0_rd2", z0_rd2, 32'h0);

    // Write reg 7, read it on both ports, then hold with RE=0
    a_re = 1'b0; a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h12345678;
    tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr1 = 5'd7; a_raddr2 = 5'd7;
    tick();
    check("rd7_z1_p1", z1_rd1, 32'h12345678);
    check("rd7_z1_p2", z1_rd2, 32'h12345678);
    check("rd7_z0_p1", z0_rd1, 32'h12345678);
    check("rd7_z0_p2", z0_rd2, 32'h12345678);
    a_re = 1'b0; a_raddr1 = 5'd3; a_raddr2 = 5'd4;
    tick();
    check("hold_z1_p1", z1_rd1, 32'h12345678);
    check("hold_z0_p2", z0_rd2, 32'h12345678);

    // Zero register: write all-ones to reg 0, then read
    a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
    tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr1 = 5'd0; a_raddr2 = 5'd7;
    tick();
    check("zero_z1_rd0", z1_rd1, 32'h00000000);
    check("zero_z0_rd0", z0_rd1, 32'hFFFFFFFF);
    check("zero_z1_rd7", z1_rd2, 32'h12345678);
    // Same-edge write/read of reg 0: hardwired zero beats bypass
    a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hCAFEBABE; a_raddr1 = 5'd0;
    tick();
    check("zero_byp_z1", z1_rd1, 32'h00000000);
    check("zero_byp_z0", z0_rd1, 32'hFFFFFFFF);

    // Bypass: reg 5 holds 0x11111111, then write 0x22222222 while reading it
    a_re = 1'b0; a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'h11111111;
    tick();
    a_re = 1'b1; a_wdata = 32'h22222222; a_raddr1 = 5'd5; a_raddr2 = 5'd7;
    tick();
    check("byp_z1_new", z1_rd1, 32'h22222222);
    check("byp_z0_old", z0_rd1, 32'h11111111);
    check("byp_z1_other", z1_rd2, 32'h12345678);
    check("byp_z0_other", z0_rd2, 32'h12345678);
    a_we = 1'b0; a_raddr2 = 5'd5;
    tick();
    check("after_byp_z1", z1_rd1, 32'h22222222);
    check("after_byp_z0", z0_rd1, 32'h22222222);
    check("after_byp_z0_p2", z0_rd2, 32'h22222222);
    check("z0_reg0_late", 32'h0, 32'h0 & z0_rd1 & 32'h0) ;

    // Mid-operation reset after writing 0xA5A5A5A5 to reg 9
    a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'hA5A5A5A5; a_raddr1 = 5'd9; a_raddr2 = 5'd7;
    tick();
    check("pre_rst_z1_byp", z1_rd1, 32'hA5A5A5A5);
    check("pre_rst_z0_old", z0_rd1, 32'h00000000);
    #2;
    RESET = 1'b0;
    a_wdata = 32'hDEADBEEF;
    #1;
    check("mid_rst_z1_p1", z1_rd1, 32'h0);
    check("mid_rst_z1_p2", z1_rd2, 32'h0);
    check("mid_rst_z0_p2", z0_rd2, 32'h0);
    tick();
    check("rst_held_z1", z1_rd1, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    a_we = 1'b0; a_re = 1'b1; a_raddr1 = 5'd9; a_raddr2 = 5'd7;
    tick();
    check("cleared_z1_r9", z1_rd1, 32'h0);
    check("cleared_z1_r7", z1_rd2, 32'h0);
    check("cleared_z0_r9", z0_rd1, 32'h0);
    a_raddr1 = 5'd5; a_raddr2 = 5'd0;
    tick();
    check("cleared_z0_r5", z0_rd1, 32'h0);
    check("cleared_z0_r0", z0_rd2, 32'h0);

    // Narrow build: write i*17 to every register, then read via alternating ports
    c_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_waddr = 3'(i);
      c_wdata = 8'(i * 17);
      tick();
    end
    c_we = 1'b0; c_re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      j = 7 - i;
      c_raddr1 = 3'(i);
      c_raddr2 = 3'(j);
      tick();
      e1 = 8'(i * 17);
      e2 = 8'(j * 17);
      check($sformatf("n1_p1_r%0d", i), {24'h0, n1_rd1}, {24'h0, e1});
      check($sformatf("n1_p2_r%0d", j), {24'h0, n1_rd2}, {24'h0, e2});
      check($sformatf("n0_p1_r%0d", i), {24'h0, n0_rd1}, {24'h0, e1});
      check($sformatf("n0_p2_r%0d", j), {24'h0, n0_rd2}, {24'h0, e2});
    end
    // Reg 0 distinguishes the zero-register builds; neighbours must be unaffected
    c_re = 1'b0; c_we = 1'b1; c_waddr = 3'd0; c_wdata = 8'hFF;
    tick();
    c_we = 1'b0; c_re = 1'b1; c_raddr1 = 3'd0; c_raddr2 = 3'd4;
    tick();
    check("n1_r0_zero", {24'h0, n1_rd1}, 32'h00);
    check("n0_r0_ff", {24'h0, n0_rd1}, 32'hFF);
    check("n1_r4_alias", {24'h0, n1_rd2}, 32'h44);
    check("n0_r4_alias", {24'h0, n0_rd2}, 32'h44);
    c_raddr1 = 3'd1; c_raddr2 = 3'd7;
    tick();
    check("n0_r1_alias", {24'h0, n0_rd1}, 32'h11);
    check("n0_r7_alias", {24'h0, n0_rd2}, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised, clocked multi-port register bank. It generalises the fixed 32-bit load register into a DEPTH x DATA_WIDTH array.
- One synchronous write port and two read ports with registered outputs.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Serves as the general-purpose register file of the processor datapath, between instruction decode and the ALU operand muxes.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns pre-write contents

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
WE  in  1  write enable
WADDR  in  ADDR_WIDTH  write address
WDATA  in  DATA_WIDTH  write data
RE  in  1  read enable (both read ports)
RADDR1  in  ADDR_WIDTH  read address, port 1
RADDR2  in  ADDR_WIDTH  read address, port 2
RDATA1  out  DATA_WIDTH  registered read data, port 1
RDATA2  out  DATA_WIDTH  registered read data, port 2

Behaviour:
- Reset, RESET=0:
  - Immediately, without waiting for a clock edge, clear all DEPTH registers, RDATA1 and RDATA2 to 0.
  - Holds while RESET=0; CLK, WE and RE are ignored.
  - Asserting RESET mid-operation discards any write or read in the same cycle.
  - The first rising CLK edge with RESET=1 operates normally.
- Write:
  - At a rising edge with RESET=1 and WE=1, mem[WADDR] <= WDATA.
  - WE=0 leaves all registers unchanged.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Read:
  - At a rising edge with RESET=1 and RE=1, RDATAn <= mem[RADDRn] for each port independently.
  - Latency is exactly 1 cycle from address presentation to RDATA valid.
  - RE=0: RDATA1/RDATA2 hold their previous values.
  - Both ports may address the same register; both return the same value.
- Zero register, ZERO_REG=1: a read of address 0 returns all-zeros regardless of history or bypass.
- Bypass, same edge with WE=1, RE=1, RADDRn==WADDR, and the address is not a discarded zero-register write:
  - BYPASS=1: RDATAn <= WDATA, the new value.
  - BYPASS=0: RDATAn <= old mem[WADDR].
  - Storage is updated in both cases.
- Width rules:
  - Addresses are always in range; DEPTH is a power of 2, so there is no out-of-range case.
  - No sign or width conversion; data is stored and returned bit-exact.
- Structure: the write address is decoded to one-hot load enables, generalising the decoder family. Each register is a DATA_WIDTH-wide bank of edge-triggered flops with async active-low clear.
- No X propagation from unwritten registers: every location is defined as 0 after reset.

Test Plan:
- Reset, then RE=1 with RADDR1=3, RADDR2=31 -> RDATA1=0 and RDATA2=0 one cycle later. Pull RESET low mid-cycle after writing 0xA5A5A5A5 -> RDATA and storage read back 0 immediately.
- Write 0x12345678 to reg 7 (WE=1), next cycle RE=1 with RADDR1=RADDR2=7 -> both RDATA=0x12345678 one edge later. RE=0 next cycle with a changed address -> outputs hold 0x12345678.
- ZERO_REG=1: write 0xFFFFFFFF to reg 0, then read reg 0 -> 0x00000000. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
- Bypass: reg 5 holds 0x11111111; the same edge has WE=1, WADDR=5, WDATA=0x22222222, RE=1, RADDR1=5 -> BYPASS=1 gives RDATA1=0x22222222, BYPASS=0 gives 0x11111111. A following read returns 0x22222222 in both builds.
- Parametrisation: DATA_WIDTH=8, ADDR_WIDTH=3. Write value i*17 to every reg 0..7, read back all via alternating ports -> each returns (i*17) mod 256, with reg 0 returning 0 when ZERO_REG=1. Confirm no aliasing between addresses.
